// File: rtl/pipeline_hazard_controller.sv
// Purpose: hazard sequencer for a 5-stage pipeline. It tracks the EX/MEM/WB destinations and derives
//          stall, flush, bubble and freeze controls plus registered EX forwarding selects.
// Latency: control outputs are combinational in the current cycle; fwd selects, pipe_state and
//          stall_cycles update on the same edge that moves the ID instruction into EX.
// Backpressure: mem_ready low on a MEM memory op freezes the whole pipeline and holds all tracked state.
// Ports: clk/reset_n (async active-low); id_* describe the ID-stage instruction; branch_taken_ex and
//        mem_ready are the EX and MEM status inputs; the outputs drive the PC write enable, the IF/ID
//        and ID/EX registers and the EX operand muxes.
module pipeline_hazard_controller #(
   parameter int         CNT_WIDTH = 16,
   parameter logic [3:0] PC_REG    = 4'd15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 id_valid,
   input  logic [3:0]           id_rn,
   input  logic [3:0]           id_rm,
   input  logic                 id_uses_rn,
   input  logic                 id_uses_rm,
   input  logic [3:0]           id_rd,
   input  logic                 id_reg_write,
   input  logic                 id_mem_enable,
   input  logic                 id_mem_rw,
   input  logic                 branch_taken_ex,
   input  logic                 mem_ready,
   output logic                 pc_write_enable,
   output logic                 stall_if_id,
   output logic                 flush_if_id,
   output logic                 bubble_ex,
   output logic                 freeze,
   output logic [1:0]           fwd_a_sel,
   output logic [1:0]           fwd_b_sel,
   output logic [1:0]           pipe_state,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   typedef struct packed {
      logic       valid;
      logic [3:0] rd;
      logic       reg_write;
      logic       is_load;
      logic       is_mem;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_MEM_WAIT   = 2'b10,
      ST_FLUSH      = 2'b11
   } state_t;

   sb_entry_t sb_ex, sb_mem, sb_wb;
   sb_entry_t ex_next;
   state_t    state_q, event_now;
   logic      ev_mem_wait, ev_flush, ev_load_stall, load_use;
   logic [1:0] fwd_a_next, fwd_b_next;

   // Priority chain: a stalled memory access beats a branch, which beats a load-use stall.
   assign ev_mem_wait   = sb_mem.valid & sb_mem.is_mem & ~mem_ready;
   assign ev_flush      = ~ev_mem_wait & branch_taken_ex & sb_ex.valid;
   assign load_use      = (id_uses_rn & (id_rn == sb_ex.rd)) | (id_uses_rm & (id_rm == sb_ex.rd));
   assign ev_load_stall = ~ev_mem_wait & ~ev_flush & sb_ex.valid & sb_ex.is_load &
                          sb_ex.reg_write & id_valid & load_use;

   always_comb begin
      event_now = ST_RUN;
      if (ev_mem_wait)        event_now = ST_MEM_WAIT;
      else if (ev_flush)      event_now = ST_FLUSH;
      else if (ev_load_stall) event_now = ST_LOAD_STALL;
   end

   assign freeze          = ev_mem_wait;
   assign stall_if_id     = ev_mem_wait | ev_load_stall;
   assign pc_write_enable = ~(ev_mem_wait | ev_load_stall);
   assign flush_if_id     = ev_flush;
   assign bubble_ex       = ev_flush | ev_load_stall;

   // Forward select for one source of the instruction entering EX. A load still in EX cannot
   // forward (its data is not ready); the stall guarantees it is in MEM by the time it is needed.
   function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used,
                                          input sb_entry_t ex_e, input sb_entry_t mem_e);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && src != PC_REG) begin
         if (ex_e.valid && ex_e.reg_write && ex_e.rd == src && !ex_e.is_load)
            sel = 2'b01;
         else if (mem_e.valid && mem_e.reg_write && mem_e.rd == src)
            sel = 2'b10;
      end
      return sel;
   endfunction

   always_comb begin
      ex_next    = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                     is_load: id_mem_enable & ~id_mem_rw, is_mem: id_mem_enable};
      fwd_a_next = fwd_sel(id_rn, id_uses_rn, sb_ex, sb_mem);
      fwd_b_next = fwd_sel(id_rm, id_uses_rm, sb_ex, sb_mem);
      if (bubble_ex) begin
         ex_next    = '0;
         fwd_a_next = 2'b00;
         fwd_b_next = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb_ex        <= '0;
         sb_mem       <= '0;
         sb_wb        <= '0;
         fwd_a_sel    <= 2'b00;
         fwd_b_sel    <= 2'b00;
         state_q      <= ST_RUN;
         stall_cycles <= '0;
      end else begin
         state_q <= event_now;
         if (event_now != ST_RUN && stall_cycles != {CNT_WIDTH{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
         if (!freeze) begin
            sb_wb     <= sb_mem;
            sb_mem    <= sb_ex;
            sb_ex     <= ex_next;
            fwd_a_sel <= fwd_a_next;
            fwd_b_sel <= fwd_b_next;
         end
      end
   end

   assign pipe_state = state_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequences the 5-stage pipeline around the decoder's control outputs (reg_write_enable, mem_enable, mem_rw). It keeps an internal scoreboard of the EX, MEM and WB stage destinations and generates four kinds of control:
- IF/ID stall and flush
- ID/EX bubble insertion
- registered EX-stage forwarding selects
- whole-pipeline freeze on memory wait
It sits beside the ID/EX register. Its outputs drive the PC write enable, the IF/ID register and the EX operand muxes.

Parameters:
CNT_WIDTH, 16, width of the saturating stall-cycle counter
PC_REG, 4'd15, register index that is never forwarded (PC)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction (0 = NOP/bubble)
id_rn  input  4  ID first source register
id_rm  input  4  ID second source register
id_uses_rn  input  1  ID instruction reads rn
id_uses_rm  input  1  ID instruction reads rm
id_rd  input  4  ID destination register
id_reg_write  input  1  decoder reg_write_enable
id_mem_enable  input  1  decoder mem_enable
id_mem_rw  input  1  decoder mem_rw (0 = read/load)
branch_taken_ex  input  1  EX branch resolved taken (condition passed)
mem_ready  input  1  data memory completes access this cycle
pc_write_enable  output  1  PC may update
stall_if_id  output  1  hold IF/ID register
flush_if_id  output  1  clear IF/ID to NOP
bubble_ex  output  1  load NOP into ID/EX
freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
fwd_a_sel  output  2  EX operand A: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b_sel  output  2  EX operand B, same encoding
pipe_state  output  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT, 11 FLUSH
stall_cycles  output  CNT_WIDTH  saturating count of non-RUN cycles

Behaviour:
Reset:
- clk and reset_n: one clock; reset is asynchronous and active-low.
- On reset: all scoreboard entries {valid, rd, reg_write, is_load, is_mem} cleared; fwd_*_sel = 00; stall_cycles = 0; pipe_state = RUN.
- Combinational outputs at reset: pc_write_enable = 1; all stall, flush, bubble and freeze signals = 0.
- Reset mid-freeze or mid-stall aborts immediately. Scoreboard contents are discarded.

Event derivation and priority (evaluated combinationally each cycle, highest first):
1. MEM_WAIT: MEM entry valid & is_mem & !mem_ready.
   - freeze = 1, stall_if_id = 1, pc_write_enable = 0, bubble_ex = 0.
   - Scoreboard and fwd selects hold.
   - branch_taken_ex is ignored. EX is held, so the branch is re-presented after the freeze.
2. FLUSH: branch_taken_ex & EX entry valid.
   - flush_if_id = 1, bubble_ex = 1, pc_write_enable = 1 (branch target loads).
3. LOAD_STALL: EX entry valid & is_load & reg_write & id_valid & ((id_uses_rn & id_rn == EX.rd) | (id_uses_rm & id_rm == EX.rd)).
   - stall_if_id = 1, pc_write_enable = 0, bubble_ex = 1.
4. RUN: all control outputs inactive, pc_write_enable = 1.

pipe_state register:
- Updated every edge with the event from the current cycle.
- Sequence is RUN -> LOAD_STALL -> RUN: exactly 1 stall cycle per load-use, since the load then moves to MEM.
- MEM_WAIT persists while mem_ready stays low.

Scoreboard advance (when !freeze):
- WB <= MEM; MEM <= EX.
- EX <= bubble_ex ? empty : {id_valid, id_rd, id_reg_write, id_mem_enable & !id_mem_rw, id_mem_enable}.

Forwarding (registered, computed at the same advance):
- fwd_a_sel for the incoming EX instruction:
  - 01 if the current EX entry (becoming MEM) is valid & reg_write & rd == id_rn & !is_load;
  - else 10 if the current MEM entry (becoming WB) is valid & reg_write & rd == id_rn;
  - else 00.
  - The newer stage wins.
- fwd_b_sel: same rule using id_rm.
- A source equal to PC_REG, or an unused source, forces 00.
- A bubble forces both selects to 00.

stall_cycles:
- Increments on every edge where the event is not RUN.
- Saturates at all-ones; never wraps.

Test Plan:
- LDR r1 then ADD r2,r1,r3 back to back -> one cycle with stall_if_id = 1, bubble_ex = 1, pc_write_enable = 0, pipe_state 01. Next ADD in EX has fwd_a_sel = 10. stall_cycles = 1.
- ADD r1 then SUB r4,r1,r1 -> no stall; fwd_a_sel = fwd_b_sel = 01 in SUB's EX cycle. With one unrelated instruction between -> both 10.
- STR in MEM with mem_ready low for 3 cycles and branch_taken_ex = 1 throughout -> freeze = 1 for 3 cycles, no flush. FLUSH occurs on the cycle after mem_ready rises. stall_cycles = 4.
- branch_taken_ex with a load-use also pending -> FLUSH wins: flush_if_id = 1, bubble_ex = 1, pc_write_enable = 1; no LOAD_STALL that cycle.
- Write to r15 followed by a read of r15 -> fwd selects stay 00. Force stall_cycles to all-ones, then stall -> value holds at 16'hFFFF.
- Assert reset_n = 0 mid MEM_WAIT -> all outputs return to reset values asynchronously; pipe_state = RUN.
